sensor_frame_capture: RTL and testbench

- Front-end capture stage that sits directly upstream of the Bayer/convolution pipeline.
- Samples raw sensor frame/line valid strobes and pixel data and emits one pixel per valid cycle to the next stage.
- Generates the x_cont/y_cont coordinates and the valid strobe the pipeline consumes.
- Adds start/stop arming so a capture only begins and ends on frame boundaries, and counts completed frames.

---
 rtl/sensor_frame_capture.sv | 156 +++++++++++++++
 tb/tb_sensor_frame_capture.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_frame_capture.sv
// Sensor front-end capture: registers raw fval/lval/data, arms capture on frame
// boundaries, emits one pixel per qualifying cycle with x/y coordinates and counts frames.
module sensor_frame_capture #(
    parameter int PIXEL_SIZE  = 12,
    parameter int ROW_SIZE    = 1280,
    parameter int COORD_WIDTH = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fval_in,
    input  logic                   lval_in,
    input  logic [PIXEL_SIZE-1:0]  data_in,
    input  logic                   start,
    input  logic                   stop,
    output logic [PIXEL_SIZE-1:0]  pixel_out,
    output logic                   valid_out,
    output logic [COORD_WIDTH-1:0] x_cont,
    output logic [COORD_WIDTH-1:0] y_cont,
    output logic [31:0]            frame_count,
    output logic                   busy,
    output logic [1:0]             state_dbg
);

    // valid_out is a one-cycle strobe with no ready: the downstream pipeline must
    // accept pixel_out/x_cont/y_cont in every cycle valid_out is high.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(ROW_SIZE - 1);

    state_t                 state, state_next;
    logic                   stop_pending, pending_next;
    logic                   count_inc;

    logic                   fval_d, fval_dd, lval_d;
    logic [PIXEL_SIZE-1:0]  data_d;
    logic                   frame_rise, frame_fall, qualify;

    logic [COORD_WIDTH-1:0] x_cnt, y_cnt;
    logic [COORD_WIDTH-1:0] x_cur, y_cur;
    logic [COORD_WIDTH-1:0] x_cnt_next, y_cnt_next;

    // Input sync stage plus a second fval stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fval_d  <= 1'b0;
            fval_dd <= 1'b0;
            lval_d  <= 1'b0;
            data_d  <= '0;
        end else begin
            fval_d  <= fval_in;
            fval_dd <= fval_d;
            lval_d  <= lval_in;
            data_d  <= data_in;
        end
    end

    assign frame_rise = fval_d & ~fval_dd;
    assign frame_fall = ~fval_d & fval_dd;
    assign qualify    = (state == CAPTURE) & fval_d & lval_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
        end else begin
            state        <= state_next;
            stop_pending <= pending_next;
        end
    end

    // Draining is CAPTURE with stop_pending set; stop beats start outside CAPTURE.
    always_comb begin
        state_next   = state;
        pending_next = stop_pending;
        count_inc    = 1'b0;
        case (state)
            IDLE: begin
                pending_next = 1'b0;
                if (start && !stop) state_next = ARMED;
            end
            ARMED: begin
                pending_next = 1'b0;
                if (stop)            state_next = IDLE;
                else if (frame_rise) state_next = CAPTURE;
            end
            CAPTURE: begin
                if (frame_fall) begin
                    count_inc = 1'b1;
                    if (stop_pending || stop) begin
                        state_next   = IDLE;
                        pending_next = 1'b0;
                    end
                end else if (stop) begin
                    pending_next = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    // A pixel landing on the frame_rise cycle must already see the cleared counters.
    always_comb begin
        x_cur      = frame_rise ? '0 : x_cnt;
        y_cur      = frame_rise ? '0 : y_cnt;
        x_cnt_next = x_cur;
        y_cnt_next = y_cur;
        if (qualify) begin
            if (x_cur == X_LAST) begin
                x_cnt_next = '0;
                y_cnt_next = y_cur + COORD_WIDTH'(1);
            end else begin
                x_cnt_next = x_cur + COORD_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            x_cnt <= x_cnt_next;
            y_cnt <= y_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out   <= '0;
            valid_out   <= 1'b0;
            x_cont      <= '0;
            y_cont      <= '0;
            frame_count <= '0;
        end else begin
            valid_out <= qualify;
            if (qualify) begin
                pixel_out <= data_d;
                x_cont    <= x_cur;
                y_cont    <= y_cur;
            end
            if (count_inc) frame_count <= frame_count + 32'd1;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_sensor_frame_capture.sv
// Bench for sensor_frame_capture with ROW_SIZE=4: directed coordinate checks, a table
// of arming scenarios, async reset, y wrap, and random frames against a frame-level model.
module tb_sensor_frame_capture;

    localparam int PW = 12;
    localparam int RS = 4;
    localparam int CW = 11;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_CAP   = 2;
    localparam int M_DRAIN = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fval_in = 1'b0;
    logic          lval_in = 1'b0;
    logic [PW-1:0] data_in = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [PW-1:0] pixel_out;
    logic          valid_out;
    logic [CW-1:0] x_cont, y_cont;
    logic [31:0]   frame_count;
    logic          busy;
    logic [1:0]    state_dbg;

    sensor_frame_capture #(.PIXEL_SIZE(PW), .ROW_SIZE(RS), .COORD_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .fval_in(fval_in), .lval_in(lval_in), .data_in(data_in),
        .start(start), .stop(stop), .pixel_out(pixel_out), .valid_out(valid_out),
        .x_cont(x_cont), .y_cont(y_cont), .frame_count(frame_count), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Scoreboard: expected and observed {pixel, x, y} entries
    logic [PW+2*CW-1:0] exp_q[$];
    logic [PW+2*CW-1:0] obs_q[$];
    logic [PW-1:0]      frame_px[$];

    int          n_total = 0;
    int          n_bad   = 0;
    int          m_mode  = M_IDLE;
    logic [31:0] m_count = '0;
    bit          m_cap   = 1'b0;

    always @(posedge clk) begin
        #2;
        if (valid_out === 1'b1) obs_q.push_back({pixel_out, x_cont, y_cont});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference model
    function automatic void m_pulse(input int p);
        bit st = (p & 1) != 0;
        bit sp = (p & 2) != 0;
        case (m_mode)
            M_IDLE:  if (st && !sp) m_mode = M_ARMED;
            M_ARMED: if (sp) m_mode = M_IDLE;
            M_CAP:   if (sp) m_mode = M_DRAIN;
            default: ;
        endcase
    endfunction

    function automatic void m_rise();
        if (m_mode == M_ARMED) m_mode = M_CAP;
        m_cap = (m_mode == M_CAP) || (m_mode == M_DRAIN);
    endfunction

    function automatic void m_end();
        int mx = 0;
        int my = 0;
        if (m_cap) begin
            m_count = m_count + 32'd1;
            foreach (frame_px[i]) begin
                exp_q.push_back({frame_px[i], CW'(mx), CW'(my)});
                mx++;
                if (mx == RS) begin
                    mx = 0;
                    my = (my + 1) % (1 << CW);
                end
            end
        end
        if (m_mode == M_DRAIN) m_mode = M_IDLE;
        m_cap = 1'b0;
    endfunction

    task automatic drive_gap(input int len, input int pulse);
        fval_in = 1'b0;
        lval_in = 1'b0;
        for (int i = 0; i < len; i++) begin
            start = ((pulse & 1) != 0) && (i == len / 2);
            stop  = ((pulse & 2) != 0) && (i == len / 2);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b0;
        m_pulse(pulse);
    endtask

    task automatic drive_frame(input int n_lines, input int len, input int pulse,
                               input bit rnd, input int base);
        int idx = 0;
        frame_px.delete();
        fval_in = 1'b1;
        lval_in = 1'b0;
        @(negedge clk);
        m_rise();
        for (int l = 0; l < n_lines; l++) begin
            for (int p = 0; p < len; p++) begin
                lval_in = 1'b1;
                data_in = rnd ? PW'($urandom) : PW'(base + idx);
                frame_px.push_back(data_in);
                idx++;
                @(negedge clk);
            end
            lval_in = 1'b0;
            for (int g = 0; g < 2; g++) begin
                start = (l == 0) && (g == 0) && ((pulse & 1) != 0);
                stop  = (l == 0) && (g == 0) && ((pulse & 2) != 0);
                @(negedge clk);
            end
            start = 1'b0;
            stop  = 1'b0;
        end
        m_pulse(pulse);
    endtask

    task automatic run_frame(input int gp, input int mp, input int nl, input int len,
                             input bit rnd, input int base);
        drive_gap(6, gp);
        drive_frame(nl, len, mp, rnd, base);
        fval_in = 1'b0;
        repeat (4) @(negedge clk);
        m_end();
    endtask

    task automatic check_frame(input string tag);
        int n;
        check({tag, "_count"}, 64'(frame_count), 64'(m_count));
        check({tag, "_busy"}, 64'(busy), 64'(m_mode != M_IDLE));
        check({tag, "_npix"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_pix"}, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        int gp;
        int mp;
        int nl;
        int len;
        int exp_valid;
        int exp_inc;
        bit exp_busy;
    } vec_t;

    vec_t        tbl[12];
    logic [31:0] exp_cnt;
    int          sz;

    initial begin
        // gap pulse, mid-frame pulse (1=start 2=stop 3=both), lines, line length, expectations
        tbl[0]  = '{2, 0, 1, 4,  4, 1, 1'b0};
        tbl[1]  = '{1, 2, 2, 4,  8, 1, 1'b0};
        tbl[2]  = '{0, 0, 2, 4,  0, 0, 1'b0};
        tbl[3]  = '{3, 0, 2, 4,  0, 0, 1'b0};
        tbl[4]  = '{0, 1, 2, 4,  0, 0, 1'b1};
        tbl[5]  = '{0, 0, 2, 4,  8, 1, 1'b1};
        tbl[6]  = '{1, 0, 1, 1,  1, 1, 1'b1};
        tbl[7]  = '{3, 0, 1, 3,  3, 1, 1'b0};
        tbl[8]  = '{0, 1, 2, 4,  0, 0, 1'b1};
        tbl[9]  = '{2, 0, 2, 2,  0, 0, 1'b0};
        tbl[10] = '{1, 3, 2, 5, 10, 1, 1'b0};
        tbl[11] = '{1, 0, 3, 6, 18, 1, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(valid_out), 64'(0));
        check("rst_pixel", 64'(pixel_out), 64'(0));
        check("rst_xy", 64'({x_cont, y_cont}), 64'(0));
        check("rst_count", 64'(frame_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Two full lines, data 1..8
        run_frame(1, 0, 2, 4, 1'b0, 1);
        check("basic_npix", 64'(obs_q.size()), 64'(8));
        for (int i = 0; i < obs_q.size() && i < 8; i++)
            check("basic_pix", 64'(obs_q[i]), 64'({PW'(i + 1), CW'(i % 4), CW'(i / 4)}));
        check("basic_count", 64'(frame_count), 64'(1));
        check_frame("basic");

        // Short lines of 3: wrap follows ROW_SIZE, not lval
        run_frame(0, 0, 2, 3, 1'b0, 1);
        check("short_npix", 64'(obs_q.size()), 64'(6));
        for (int i = 0; i < obs_q.size() && i < 6; i++)
            check("short_pix", 64'(obs_q[i]), 64'({PW'(i + 1), CW'(i % 4), CW'(i / 4)}));
        check("short_count", 64'(frame_count), 64'(2));
        check_frame("short");

        // Arming scenarios
        exp_cnt = 32'd2;
        for (int k = 0; k < 12; k++) begin
            run_frame(tbl[k].gp, tbl[k].mp, tbl[k].nl, tbl[k].len, 1'b1, 0);
            exp_cnt = exp_cnt + 32'(tbl[k].exp_inc);
            check($sformatf("tbl%0d_valid", k), 64'(obs_q.size()), 64'(tbl[k].exp_valid));
            check($sformatf("tbl%0d_count", k), 64'(frame_count), 64'(exp_cnt));
            check($sformatf("tbl%0d_busy", k), 64'(busy), 64'(tbl[k].exp_busy));
            check_frame($sformatf("tbl%0d", k));
        end

        // Asynchronous reset in the middle of a captured line
        drive_gap(6, 0);
        fval_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            lval_in = 1'b1;
            data_in = PW'(12'h5a1 + i);
            @(negedge clk);
        end
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 64'(valid_out), 64'(0));
        check("arst_pixel", 64'(pixel_out), 64'(0));
        check("arst_xy", 64'({x_cont, y_cont}), 64'(0));
        check("arst_count", 64'(frame_count), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        fval_in = 1'b0;
        lval_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        m_mode  = M_IDLE;
        m_count = '0;
        run_frame(0, 0, 2, 4, 1'b1, 0);
        check("post_rst_npix", 64'(obs_q.size()), 64'(0));
        check_frame("post_rst");

        // One long line crossing 2^COORD_WIDTH rows
        run_frame(1, 0, 1, 8193, 1'b1, 0);
        sz = obs_q.size();
        check("ywrap_npix", 64'(sz), 64'(8193));
        if (sz >= 2) begin
            check("ywrap_prev", 64'(obs_q[sz - 2][2*CW-1:0]), 64'({CW'(3), CW'(2047)}));
            check("ywrap_last", 64'(obs_q[sz - 1][2*CW-1:0]), 64'(0));
        end
        check_frame("ywrap");

        // Random frames and pulses
        for (int k = 0; k < 40; k++) begin
            int gp, mp, nl, len;
            gp  = $urandom_range(0, 3);
            mp  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            nl  = $urandom_range(1, 3);
            len = $urandom_range(1, 6);
            run_frame(gp, mp, nl, len, 1'b1, 0);
            check_frame($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
